rng_pool: RTL and testbench
===========================

# rng_pool

Buffered random-word source for the TPM IP. It drives the enable of an `rng_stream` instance and packs its `STREAM_BYTES`-wide chunks into `OUT_BYTES`-wide words. Completed words go into a `DEPTH`-entry prefetch FIFO, served through a valid/ready port. The FIFO refills automatically, so command logic (nonce, key-generation paths) normally gets random words with zero wait.

## Interface
Parameters:
- `OUT_BYTES`, 32, bytes per output word; must be a multiple of `STREAM_BYTES`.
- `STREAM_BYTES`, 8, bytes per stream chunk.
- `DEPTH`, 4, FIFO entries; must be ≥ 2.
- `REP_LIMIT`, 3, repetition-count threshold for the health test.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `stream_en`  out  1  enable to `rng_stream`.
- `stream_data`  in  8*STREAM_BYTES  chunk from the stream.
- `stream_valid`  in  1  `stream_data` is a fresh chunk this cycle.
- `flush`  in  1  discard all buffered and partial data.
- `rd_data`  out  8*OUT_BYTES  head-of-FIFO word.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `level`  out  $clog2(DEPTH)+1  number of words in the FIFO.
- `health_fail`  out  1  sticky health-test failure.

## Operation
- CHUNKS = OUT_BYTES/STREAM_BYTES. The assembly register fills LSB-first: chunk k goes to bytes [k*STREAM_BYTES +: STREAM_BYTES].
- FSM states:
  - IDLE: moves to COLLECT when `level` < DEPTH.
  - COLLECT: `stream_en`=1. Each cycle with `stream_valid`=1 accepts one chunk. On the CHUNKS-th accepted chunk, moves to PUSH.
  - PUSH: `stream_en`=0. Writes the assembled word to the FIFO and clears the chunk counter. Moves to COLLECT if post-update `level` < DEPTH, else to IDLE.
- FIFO read side is first-word-fall-through:
  - `rd_valid` = (`level` != 0).
  - A pop occurs on `rd_valid` && `rd_ready`.
  - Words come out in push order.
- A push and a pop in the same cycle leave `level` unchanged.
- A pop when `level`=0 is ignored.
- `flush` takes priority over everything except `rst`:
  - `level` goes to 0 and the chunk counter clears.
  - FSM goes to IDLE.
  - Any pop or push in the same cycle is discarded.
  - `health_fail` is not cleared.
- `rst` mid-assembly discards the partial word; all state returns to reset values.
- `stream_valid` while `stream_en`=0 is ignored.

## Timing
- Reset values: `stream_en`=0, `rd_valid`=0, `rd_data`=0, `level`=0, `health_fail`=0. FSM is in IDLE and the chunk counter is 0.
- After `rst` deasserts, `stream_en` rises one cycle later (IDLE→COLLECT).
- Word latency: the last chunk is captured at edge N and the FIFO is written at edge N+1. `rd_valid`/`level` update after edge N+1.
- With `stream_valid` constantly high, one word costs CHUNKS+1 cycles.
- After a pop from a full FIFO at edge M, FSM goes IDLE→COLLECT at edge M+1.
- `rd_data` changes only on a push into an empty FIFO, a pop, or `flush`/`rst`.

## Configuration
- Macro: `RNG_HEALTH_EN`.
- Defined:
  - Each accepted chunk is compared to the previously accepted chunk.
  - A run counter tracks consecutive equal chunks; any differing chunk resets it to 0.
  - When the counter reaches REP_LIMIT, the current partial word is discarded and `health_fail` is set. Counter and chunk counter both clear, and collection continues.
  - `health_fail` is sticky; only `rst` clears it.
  - Previous-chunk history resets on `rst`/`flush`.
- Undefined: no comparator or run counter is built, and `health_fail` is tied to 0.

## Structure
- `rng_pkg` holds:
  - the FSM state enum (IDLE, COLLECT, PUSH);
  - the function computing CHUNKS;
  - the REP_LIMIT default constant.
- One sub-module, `rng_pool_fifo`: parametrised FWFT FIFO (width, depth) with push, pop, flush and level. The top level contains the FSM, the assembly register and the health logic.

## Test plan
- Fill: defaults, `stream_valid`=1, chunks 1,2,3,4,… (64-bit).
  - First word = {64'h4,64'h3,64'h2,64'h1}.
  - `level` reaches 4 after 4 words; `stream_en` then stays 0.
- Drain: FIFO full, `rd_ready`=1 for 4 cycles.
  - Four words pop in order.
  - `stream_en` rises the cycle after the first pop.
  - `rd_valid` never drops while words remain.
- Simultaneous push and pop at `level`=3: `level` stays 3 and the word order is preserved.
- Flush after 2 chunks of a word at `level`=2:
  - Next cycle `level`=0 and `rd_valid`=0.
  - The next word is built from 4 fresh chunks.
- `RNG_HEALTH_EN`, REP_LIMIT=3, chunk 64'hAAAA_AAAA_AAAA_AAAA fed 4 times:
  - `health_fail`=1 after the 4th chunk; no word is pushed.
  - Later distinct chunks produce words normally.
  - `rst` clears `health_fail`.
- `rst` asserted mid-assembly with `level`=2: all outputs at reset values the next cycle, and refill restarts.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and constants for the rng_pool random-word buffer.
package rng_pkg;

    // Word-assembly controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUSH    = 2'd2
    } state_t;

    // Default repetition-count threshold for the stream health test.
    localparam int REP_LIMIT_DEFAULT = 3;

    // Number of stream chunks that make up one output word.
    function automatic int chunks_per_word(input int out_bytes, input int stream_bytes);
        return out_bytes / stream_bytes;
    endfunction

endpackage

// File: rtl/rng_pool_fifo.sv
// First-word-fall-through FIFO holding completed random words.
// The head entry is presented on rd_data whenever level is non-zero;
// an empty FIFO presents zero. Flush empties the FIFO and wins over
// any push or pop in the same cycle.
module rng_pool_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_eff;
    logic             push_eff;

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // taken when a pop frees the slot in the same cycle.
    assign pop_eff  = pop && (level != '0) && !flush;
    assign push_eff = push && ((level != LW'(DEPTH)) || pop_eff) && !flush;

    assign rd_data = (level != '0) ? mem[rd_ptr] : '0;

    // Wrap a pointer at DEPTH so non-power-of-two depths also work.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    // Pointer and occupancy tracking.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_eff) wr_ptr <= next_ptr(wr_ptr);
            if (pop_eff)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_eff, pop_eff})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Word storage.
    // NOTE: the storage array has no reset; entries are only visible while
    // level covers them, so stale contents never reach rd_data.
    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rng_pool.sv
// Buffered random-word source: drives rng_stream's enable, packs
// STREAM_BYTES-wide chunks LSB-first into OUT_BYTES-wide words and keeps
// a DEPTH-entry prefetch FIFO topped up behind a valid/ready read port.
// Optional feature macro: RNG_HEALTH_EN adds a repetition-count health
// test on the incoming chunks; without it health_fail is tied low.
module rng_pool
    import rng_pkg::*;
#(
    parameter int OUT_BYTES    = 32,
    parameter int STREAM_BYTES = 8,
    parameter int DEPTH        = 4,
    parameter int REP_LIMIT    = REP_LIMIT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        stream_en,
    input  logic [8*STREAM_BYTES-1:0]   stream_data,
    input  logic                        stream_valid,
    input  logic                        flush,
    output logic [8*OUT_BYTES-1:0]      rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        health_fail
);

    localparam int CHUNKS = chunks_per_word(OUT_BYTES, STREAM_BYTES);
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int SW     = 8 * STREAM_BYTES;
    localparam int OW     = 8 * OUT_BYTES;
    localparam int LW     = $clog2(DEPTH) + 1;

    state_t          state;
    logic [CW-1:0]   chunk_cnt;
    logic [OW-1:0]   asm_word;
    logic            accept;
    logic            last_chunk;
    logic            push;
    logic            pop_ok;
    logic [LW-1:0]   level_after;
    logic            health_trip;

    // A chunk is taken only while collecting; flush discards it.
    assign accept     = (state == COLLECT) && stream_valid && !flush;
    assign last_chunk = (chunk_cnt == CW'(CHUNKS - 1));
    assign push       = (state == PUSH) && !flush;
    assign rd_valid   = (level != '0);
    assign pop_ok     = rd_valid && rd_ready;

    // Occupancy after this cycle's push (PUSH only ever runs with a free slot).
    assign level_after = level + LW'(1) - LW'(pop_ok);

    // Word-assembly controller with registered stream enable.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= IDLE;
            chunk_cnt <= '0;
            stream_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (level < LW'(DEPTH)) begin
                        state     <= COLLECT;
                        stream_en <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (health_trip) begin
                            chunk_cnt <= '0;
                        end else if (last_chunk) begin
                            state     <= PUSH;
                            stream_en <= 1'b0;
                        end else begin
                            chunk_cnt <= chunk_cnt + CW'(1);
                        end
                    end
                end
                PUSH: begin
                    chunk_cnt <= '0;
                    if (level_after < LW'(DEPTH)) begin
                        state     <= COLLECT;
                        stream_en <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        stream_en <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    stream_en <= 1'b0;
                    chunk_cnt <= '0;
                end
            endcase
        end
    end

    // Assembly register: chunk k lands in byte lane k*STREAM_BYTES upward.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_word <= '0;
        end else if (accept) begin
            asm_word[int'(chunk_cnt)*SW +: SW] <= stream_data;
        end
    end

`ifdef RNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [SW-1:0] prev_chunk;
    logic          have_prev;
    logic [RW-1:0] run_cnt;
    logic          fail_reg;
    logic          same;

    assign same        = have_prev && (stream_data == prev_chunk);
    assign health_trip = accept && same && (run_cnt == RW'(REP_LIMIT - 1));
    assign health_fail = fail_reg;

    // Repetition-count test; the failure flag survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_chunk <= '0;
            have_prev  <= 1'b0;
            run_cnt    <= '0;
            fail_reg   <= 1'b0;
        end else if (flush) begin
            prev_chunk <= '0;
            have_prev  <= 1'b0;
            run_cnt    <= '0;
        end else if (accept) begin
            prev_chunk <= stream_data;
            have_prev  <= 1'b1;
            if (health_trip) begin
                run_cnt  <= '0;
                fail_reg <= 1'b1;
            end else if (same) begin
                run_cnt <= run_cnt + RW'(1);
            end else begin
                run_cnt <= '0;
            end
        end
    end
`else
    assign health_trip = 1'b0;
    assign health_fail = 1'b0;
`endif

    rng_pool_fifo #(
        .WIDTH (OW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (asm_word),
        .pop       (rd_ready),
        .rd_data   (rd_data),
        .level     (level)
    );

endmodule

// File: tb/tb_rng_pool.sv
// Self-checking bench for rng_pool (default parameters). A transaction-level
// model (word queue, partial-chunk list, pending-word slot) predicts the
// outputs each cycle; directed steps pin the model with literal values.
// Health-test expectations follow the RNG_HEALTH_EN build setting.
module tb_rng_pool;

    localparam int DEPTH     = 4;
    localparam int REP_LIMIT = 3;
    localparam int CHUNKS    = 4;
    localparam int SW        = 64;
    localparam int OW        = 256;
    localparam int LW        = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          stream_valid;
    logic          rd_ready;
    logic          stream_en;
    logic          rd_valid;
    logic          health_fail;
    logic [SW-1:0] stream_data;
    logic [OW-1:0] rd_data;
    logic [LW-1:0] level;

    logic          use_fixed;
    logic [SW-1:0] fixed_val;
    logic [SW-1:0] src_val;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign stream_data = use_fixed ? fixed_val : src_val;

    rng_pool dut (
        .clk          (clk),
        .rst          (rst),
        .stream_en    (stream_en),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .flush        (flush),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .level        (level),
        .health_fail  (health_fail)
    );

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [OW-1:0] mq[$];
    logic [SW-1:0] part[$];
    bit            pend;
    logic [OW-1:0] pend_word;
    logic [SW-1:0] prev;
    bit            have_prev;
    int            run;
    bit            hf;
    bit            trip;
    logic          en_prev = 1'b0;

    function automatic logic [OW-1:0] pack(input logic [SW-1:0] c[$]);
        logic [OW-1:0] w = '0;
        for (int i = 0; i < c.size(); i++) w[i*SW +: SW] = c[i];
        return w;
    endfunction

    // At each falling edge: apply the rules for the rising edge just past,
    // compare DUT outputs, then advance the stream source.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete(); part.delete();
            pend = 0; have_prev = 0; run = 0; hf = 0;
        end else if (flush) begin
            mq.delete(); part.delete();
            pend = 0; have_prev = 0; run = 0;
        end else begin
            if (rd_ready && mq.size() != 0) void'(mq.pop_front());
            if (pend) begin
                mq.push_back(pend_word);
                pend = 0;
            end
            if (en_prev && stream_valid) begin
                trip = 0;
`ifdef RNG_HEALTH_EN
                if (have_prev && stream_data == prev) run++;
                else run = 0;
                prev = stream_data;
                have_prev = 1;
                if (run == REP_LIMIT) begin
                    trip = 1; run = 0; hf = 1;
                    part.delete();
                end
`endif
                if (!trip) begin
                    part.push_back(stream_data);
                    if (part.size() == CHUNKS) begin
                        pend_word = pack(part);
                        pend = 1;
                        part.delete();
                    end
                end
            end
        end

        check("m_level", OW'(level), OW'(mq.size()));
        check("m_rd_valid", OW'(rd_valid), OW'(mq.size() != 0));
        check("m_rd_data", rd_data, (mq.size() != 0) ? mq[0] : '0);
        check("m_health", OW'(health_fail), OW'(hf));
        if (mq.size() == DEPTH) check("m_en_when_full", OW'(stream_en), '0);

        if (rst) src_val = 64'd1;
        else if (en_prev && stream_valid && !flush) src_val = src_val + 64'd1;
        en_prev = stream_en;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_level(input int target, input string name);
        int n = 0;
        while (int'(level) != target && n < 100) begin
            tick();
            n++;
        end
        check(name, OW'(level), OW'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, OW'(stream_en), '0);
        check({tag, "_valid"}, OW'(rd_valid), '0);
        check({tag, "_data"}, rd_data, '0);
        check({tag, "_level"}, OW'(level), '0);
        check({tag, "_health"}, OW'(health_fail), '0);
    endtask

    initial begin
        logic [SW-1:0] s;
        int ticks;
        logic [OW-1:0] exp_w;

        rst = 1'b1; flush = 1'b0; stream_valid = 1'b0; rd_ready = 1'b0;
        use_fixed = 1'b0; fixed_val = 64'hAAAA_AAAA_AAAA_AAAA;
        repeat (3) tick();
        check_reset_outputs("reset");

        // Fill with chunks 1,2,3,... until the FIFO is full.
        rst = 1'b0;
        stream_valid = 1'b1;
        tick();
        check("en_after_rst", OW'(stream_en), OW'(1));
        ticks = 1;
        while (level != LW'(DEPTH) && ticks < 60) begin
            tick();
            ticks++;
        end
        check("fill_cycles", OW'(ticks), OW'(21));
        check("first_word", rd_data, {64'h4, 64'h3, 64'h2, 64'h1});
        repeat (5) begin
            tick();
            check("full_en_low", OW'(stream_en), '0);
            check("full_level", OW'(level), OW'(4));
        end

        // Drain four words in order.
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_w = {64'(4*i+4), 64'(4*i+3), 64'(4*i+2), 64'(4*i+1)};
            check("drain_valid", OW'(rd_valid), OW'(1));
            check("drain_word", rd_data, exp_w);
            tick();
            if (i == 0) check("drain_en_m", OW'(stream_en), '0);
            if (i == 1) check("drain_en_m1", OW'(stream_en), OW'(1));
        end
        rd_ready = 1'b0;
        check("drain_empty", OW'(level), '0);

        // Simultaneous push and pop at level 3.
        wait_level(3, "reach_level3");
        repeat (4) tick();
        check("pushpop_en_in_push", OW'(stream_en), '0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("pushpop_level", OW'(level), OW'(3));

        // Flush (with a pop request) from level 3, then pop on empty.
        flush = 1'b1; rd_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_level", OW'(level), '0);
        check("flush_valid", OW'(rd_valid), '0);
        check("flush_en", OW'(stream_en), '0);
        tick();
        rd_ready = 1'b0;
        check("empty_pop_level", OW'(level), '0);
        check("flush_en_rise", OW'(stream_en), OW'(1));

        // Flush after two chunks of a word at level 2.
        wait_level(2, "reach_level2");
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush2_level", OW'(level), '0);
        check("flush2_valid", OW'(rd_valid), '0);
        s = src_val;
        wait_level(1, "refill_after_flush");
        check("fresh_word", rd_data, {s + 64'd3, s + 64'd2, s + 64'd1, s});

        // Repeated chunk fed four times from a clean state.
        use_fixed = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
`ifdef RNG_HEALTH_EN
        check("health_set", OW'(health_fail), OW'(1));
        check("health_no_word", OW'(level), '0);
        use_fixed = 1'b0;
        s = src_val;
        tick();
        check("health_still_none", OW'(level), '0);
        check("health_sticky", OW'(health_fail), OW'(1));
        wait_level(1, "health_resume");
        check("health_next_word", rd_data, {s + 64'd3, s + 64'd2, s + 64'd1, s});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("health_rst_clear", OW'(health_fail), '0);
`else
        check("health_tied_low", OW'(health_fail), '0);
        use_fixed = 1'b0;
        tick();
        check("repeat_word_level", OW'(level), OW'(1));
        check("repeat_word", rd_data, {4{64'hAAAA_AAAA_AAAA_AAAA}});
`endif

        // Reset mid-assembly at level 2.
        wait_level(2, "reach_level2_rst");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        check("midrst_en_rise", OW'(stream_en), OW'(1));
        wait_level(1, "midrst_refill");
        check("midrst_word", rd_data, {64'h4, 64'h3, 64'h2, 64'h1});

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
